// File: rtl/glitc_debug_pkg.sv
// Shared definitions for the GLITC debug capture buffer.
//   state_t       : FSM state codes reported on state_o
//   DEFAULT_WIDTH : default debug word width
//   TS_WIDTH      : width of the trigger timestamp
package glitc_debug_pkg;

    localparam int unsigned DEFAULT_WIDTH = 71;
    localparam int unsigned TS_WIDTH      = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/glitc_debug_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// No reset on the storage or read register so it maps onto block RAM.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request and address
//   rdata        : read data, one cycle after re
module glitc_debug_capture_ram
    import glitc_debug_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/glitc_debug_capture.sv
// Trigger-based capture buffer for the GLITC debug bus. Records a window of
// 2^DEPTH_LOG2 words around a trigger (pretrig words before it) and plays it
// back in chronological order, one word per rd_req_i, two cycles later.
// Optional feature: define GLITC_DEBUG_CAPTURE_TIMESTAMP_EN to latch a
// free-running cycle count on trigger into trig_time_o (otherwise tied to 0).
//   clk_i, rst_i       : clock, async active-high reset
//   debug_i            : debug word sampled every active cycle
//   arm_i, pretrig_i   : start a capture, pre-trigger word count
//   trig_i             : trigger (level-sampled in ARMED)
//   rd_req_i           : request next readout word (DONE only)
//   rd_data_o/rd_valid_o : readout word and its valid
//   state_o, done_o    : FSM state code, capture complete
//   trig_time_o        : trigger timestamp
module glitc_debug_capture
    import glitc_debug_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WIDTH      = DEFAULT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [WIDTH-1:0]      debug_i,
    input  logic                  arm_i,
    input  logic [DEPTH_LOG2-1:0] pretrig_i,
    input  logic                  trig_i,
    input  logic                  rd_req_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  rd_valid_o,
    output logic [2:0]            state_o,
    output logic                  done_o,
    output logic [TS_WIDTH-1:0]   trig_time_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    state_t                state;
    logic [DEPTH_LOG2-1:0] pretrig_q;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] trig_addr;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W-1:0]      post_len;
    logic                  wr_en;
    logic                  trig_hit;
    logic                  rd_fire;
    logic                  rd_pend;
    logic [WIDTH-1:0]      ram_q;

    // Arm always takes priority over writes, triggers and reads.
    assign wr_en    = !arm_i && (state == ST_PRE || state == ST_ARMED || state == ST_POST);
    assign trig_hit = !arm_i && (state == ST_ARMED) && trig_i;
    assign rd_fire  = !arm_i && (state == ST_DONE) && rd_req_i;

    assign cnt_inc  = cnt + CNT_W'(1);
    assign post_len = CNT_W'(DEPTH) - CNT_W'(pretrig_q);
    // Window starts pretrig words before the trigger word; wraps mod depth.
    assign rd_addr  = trig_addr - pretrig_q + rd_idx;
    assign state_o  = state;

    // Capture FSM; cnt counts PRE words, then POST words including the trigger word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            done_o    <= 1'b0;
            pretrig_q <= '0;
            wr_ptr    <= '0;
            trig_addr <= '0;
            rd_idx    <= '0;
            cnt       <= '0;
        end else if (arm_i) begin
            state     <= (pretrig_i == '0) ? ST_ARMED : ST_PRE;
            done_o    <= 1'b0;
            pretrig_q <= pretrig_i;
            wr_ptr    <= '0;
            rd_idx    <= '0;
            cnt       <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (rd_fire) begin
                rd_idx <= rd_idx + DEPTH_LOG2'(1);
            end
            case (state)
                ST_PRE: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == CNT_W'(pretrig_q)) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        trig_addr <= wr_ptr;
                        cnt       <= CNT_W'(1);
                        // Trigger word alone may complete the window.
                        if (post_len == CNT_W'(1)) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    cnt <= cnt_inc;
                    if (cnt_inc == post_len) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read pipeline: RAM register then output register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_pend    <= 1'b0;
            rd_valid_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            rd_pend    <= rd_fire;
            rd_valid_o <= rd_pend;
            if (rd_pend) begin
                rd_data_o <= ram_q;
            end
        end
    end

    glitc_debug_capture_ram #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk_i),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (debug_i),
        .re    (rd_fire),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

`ifdef GLITC_DEBUG_CAPTURE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;

    // Free-running cycle counter; its value in the trigger cycle is held until re-arm.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_cnt      <= '0;
            trig_time_o <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            if (arm_i) begin
                trig_time_o <= '0;
            end else if (trig_hit) begin
                trig_time_o <= ts_cnt;
            end
        end
    end
`else
    assign trig_time_o = '0;
`endif

endmodule

// File: tb/tb_glitc_debug_capture.sv
// Self-checking bench for glitc_debug_capture (DEPTH_LOG2=4). A behavioural
// model tracks words written since arm and where the trigger fell; the
// captured window is simply the last 16 words written.
module tb_glitc_debug_capture;

    localparam int unsigned DL = 4;
    localparam int unsigned W  = 71;
    localparam int          D  = 16;
`ifdef GLITC_DEBUG_CAPTURE_TIMESTAMP_EN
    localparam bit TS_EN = 1'b1;
`else
    localparam bit TS_EN = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [W-1:0]  debug_i;
    logic          arm_i;
    logic [DL-1:0] pretrig_i;
    logic          trig_i;
    logic          rd_req_i;
    logic [W-1:0]  rd_data_o;
    logic          rd_valid_o;
    logic [2:0]    state_o;
    logic          done_o;
    logic [31:0]   trig_time_o;

    glitc_debug_capture #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .debug_i     (debug_i),
        .arm_i       (arm_i),
        .pretrig_i   (pretrig_i),
        .trig_i      (trig_i),
        .rd_req_i    (rd_req_i),
        .rd_data_o   (rd_data_o),
        .rd_valid_o  (rd_valid_o),
        .state_o     (state_o),
        .done_o      (done_o),
        .trig_time_o (trig_time_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- behavioural model ----------------
    bit           m_armed = 1'b0;
    int           m_pre   = 0;
    int           m_nw    = 0;   // words written since arm
    int           m_trig  = -1;  // write index of trigger word, -1 if none yet
    int           m_rdidx = 0;
    logic [W-1:0] hist [4096];
    bit           p1_v    = 1'b0;
    logic [W-1:0] p1_d    = '0;
    bit           e_valid = 1'b0;
    logic [W-1:0] e_data  = '0;
    logic [31:0]  m_ts    = '0;
    logic [31:0]  m_tt    = '0;
    int           m_st    = 0;

    function automatic int mstate();
        if (!m_armed)     return 0;
        if (m_trig < 0)   return (m_nw < m_pre) ? 1 : 2;
        return ((m_nw - m_trig) < (D - m_pre)) ? 3 : 4;
    endfunction

    initial forever begin
        @(posedge clk_i or posedge rst_i);
        if (rst_i) begin
            m_armed = 1'b0; m_pre = 0; m_nw = 0; m_trig = -1; m_rdidx = 0;
            p1_v = 1'b0; e_valid = 1'b0; e_data = '0; m_ts = '0; m_tt = '0;
        end else begin
            m_st    = mstate();
            e_valid = p1_v;
            if (p1_v) e_data = p1_d;
            p1_v = 1'b0;
            if (arm_i) begin
                m_armed = 1'b1; m_pre = int'(pretrig_i); m_nw = 0; m_trig = -1;
                m_rdidx = 0; m_tt = '0;
            end else if (m_st >= 1 && m_st <= 3) begin
                if (m_st == 2 && trig_i) begin
                    m_trig = m_nw;
                    m_tt   = m_ts;
                end
                hist[12'(m_nw)] = debug_i;
                m_nw++;
            end else if (m_st == 4 && rd_req_i) begin
                p1_v    = 1'b1;
                p1_d    = hist[12'(m_nw - D + m_rdidx)];
                m_rdidx = (m_rdidx + 1) % D;
            end
            m_ts = m_ts + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk_i);
        chk("state",     128'(state_o),     128'(mstate()));
        chk("done",      128'(done_o),      128'(mstate() == 4));
        chk("rd_valid",  128'(rd_valid_o),  128'(e_valid));
        chk("rd_data",   128'(rd_data_o),   128'(e_data));
        chk("trig_time", 128'(trig_time_o), TS_EN ? 128'(m_tt) : 128'(0));
    end

    // ---------------- stimulus ----------------
    int          cyc = 0;
    logic [31:0] got [$];
    int          first_v;
    int          bad;

    task automatic tick(input logic a, input logic [DL-1:0] p, input logic t, input logic r);
        @(negedge clk_i);
        arm_i     = a;
        pretrig_i = p;
        trig_i    = t;
        rd_req_i  = r;
        debug_i   = {7'($urandom), 32'($urandom), 32'(cyc)};
        cyc++;
    endtask

    task automatic idle();
        tick(1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reads(input int n);
        got.delete();
        first_v = -1;
        for (int i = 0; i < n + 3; i++) begin
            tick(1'b0, 4'd0, 1'b0, i < n);
            if (rd_valid_o) begin
                if (first_v < 0) first_v = i;
                got.push_back(rd_data_o[31:0]);
            end
        end
    endtask

    task automatic seq_check(input string name, input int base);
        bad = 0;
        for (int i = 0; i < got.size(); i++)
            if (got[i] != 32'(base + (i % D))) bad++;
        chk(name, 128'(bad), 128'(0));
    endtask

    initial begin
        rst_i = 1'b1; arm_i = 1'b0; pretrig_i = '0; trig_i = 1'b0; rd_req_i = 1'b0; debug_i = '0;
        repeat (2) @(negedge clk_i);
        chk("reset_state", 128'(state_o), 128'(0));
        chk("reset_done",  128'(done_o),  128'(0));
        chk("reset_valid", 128'(rd_valid_o), 128'(0));
        rst_i = 1'b0;

        // Basic capture: pretrig 4, trigger on word 20.
        cyc = 0;
        tick(1'b1, 4'd4, 1'b0, 1'b0);
        repeat (19) idle();
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            idle();
            if (k == 11) chk("basic_done_early", 128'(done_o), 128'(0));
            if (k == 12) chk("basic_done_at_12", 128'(done_o), 128'(1));
        end
        do_reads(32);
        chk("basic_latency", 128'(first_v), 128'(2));
        chk("basic_count",   128'(got.size()), 128'(32));
        chk("basic_first",   128'(got[0]),  128'(16));
        chk("basic_last",    128'(got[15]), 128'(31));
        chk("basic_reread",  128'(got[16]), 128'(16));
        seq_check("basic_seq", 16);

        // Zero pretrig: straight to ARMED, trigger on word 7.
        cyc = 0;
        tick(1'b1, 4'd0, 1'b0, 1'b0);
        idle();
        chk("zero_pre_armed", 128'(state_o), 128'(2));
        repeat (5) idle();
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        repeat (18) idle();
        do_reads(16);
        chk("zero_pre_first", 128'(got[0]),  128'(7));
        chk("zero_pre_last",  128'(got[15]), 128'(22));

        // Wrap before trigger: pretrig 3, trigger on word 50.
        cyc = 0;
        tick(1'b1, 4'd3, 1'b0, 1'b0);
        repeat (49) idle();
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        repeat (16) idle();
        do_reads(16);
        chk("wrap_latency", 128'(first_v), 128'(2));
        chk("wrap_first",   128'(got[0]), 128'(47));
        seq_check("wrap_seq", 47);

        // Trigger ignored in PRE.
        tick(1'b1, 4'd8, 1'b0, 1'b0);
        idle();
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        for (int k = 3; k <= 9; k++) begin
            idle();
            if (k == 3) chk("pre_ign_s3", 128'(state_o), 128'(1));
            if (k == 8) chk("pre_ign_s8", 128'(state_o), 128'(1));
            if (k == 9) begin
                chk("pre_ign_armed", 128'(state_o), 128'(2));
                chk("pre_ign_done",  128'(done_o),  128'(0));
            end
        end
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        repeat (10) idle();

        // Re-arm with trigger in POST, then async reset in ARMED.
        tick(1'b1, 4'd2, 1'b0, 1'b0);
        repeat (4) idle();
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        repeat (3) idle();
        chk("post_before_rearm", 128'(state_o), 128'(3));
        tick(1'b1, 4'd5, 1'b1, 1'b0);
        idle();
        chk("rearm_pre",  128'(state_o), 128'(1));
        chk("rearm_done", 128'(done_o),  128'(0));
        repeat (6) idle();
        chk("rearm_armed", 128'(state_o), 128'(2));
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_state", 128'(state_o),     128'(0));
        chk("arst_done",  128'(done_o),      128'(0));
        chk("arst_valid", 128'(rd_valid_o),  128'(0));
        chk("arst_data",  128'(rd_data_o),   128'(0));
        chk("arst_ttime", 128'(trig_time_o), 128'(0));
        @(negedge clk_i);
        rst_i = 1'b0;

        // Timestamp: trigger while the counter reads 100.
        tick(1'b1, 4'd2, 1'b0, 1'b0);
        for (int k = 0; k < 300; k++) begin
            if (m_ts == 32'd99) break;
            idle();
        end
        tick(1'b0, 4'd0, 1'b1, 1'b0);
        repeat (20) idle();
        chk("ts_latched", 128'(trig_time_o), TS_EN ? 128'(100) : 128'(0));
        tick(1'b1, 4'd1, 1'b0, 1'b0);
        idle();
        chk("ts_cleared", 128'(trig_time_o), 128'(0));

        // Randomized captures, checked every cycle against the model.
        for (int r = 0; r < 12; r++) begin
            tick(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
            for (int c = 0; c < 100; c++)
                tick($urandom_range(0, 99) == 0, 4'($urandom), $urandom_range(0, 9) == 0,
                     1'($urandom_range(0, 1)));
        end
        repeat (3) idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
